// File: rtl/vnet_link_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vnet_link_pipe
//  Description : Multi-port inter-router link stage. Retimes the flit path
//                (valid, pend, VC id, look-ahead route, payload) and the
//                credit-return path by independent stage counts so long mesh
//                links close timing. An optional per-VC credit shadow flags
//                protocol violations at the upstream boundary.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option: define VNET_LINK_PIPE_CREDIT_CHECK_EN to build the credit
//                shadow and sticky error flags. When it is undefined,
//                crd_cnt_o and err_* are tied to 0 and err_clr_i is ignored.
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                  clock, synchronous active-high reset
//    up_flit_*_i               flit word from the upstream router tx
//    dn_flit_*_o               same word, FLIT_STAGES cycles later, toward rx
//    dn_lcrd_v_i/id_i          credit return from the downstream rx
//    up_lcrd_v_o/id_o          same credit, CRD_STAGES cycles later, toward tx
//    crd_cnt_o                 credit shadow per port and VC
//    err_underflow_o           sticky: flit sent on a VC with no credit
//    err_overflow_o            sticky: credit beyond VC_DEPTH or bad VC id
//    err_clr_i                 clears both sticky error vectors
// ============================================================================
module vnet_link_pipe #(
    parameter int PORT_NUM    = 5,
    parameter int FLIT_W      = 128,
    parameter int LA_W        = 3,
    parameter int VC_NUM      = 6,
    parameter int VC_ID_W     = $clog2(VC_NUM),
    parameter int VC_DEPTH    = 4,
    parameter int FLIT_STAGES = 1,
    parameter int CRD_STAGES  = 1,
    parameter int CNT_W       = $clog2(VC_DEPTH + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [PORT_NUM-1:0]                      up_flit_v_i,
    input  logic [PORT_NUM-1:0]                      up_flit_pend_i,
    input  logic [PORT_NUM-1:0][FLIT_W-1:0]          up_flit_i,
    input  logic [PORT_NUM-1:0][VC_ID_W-1:0]         up_flit_vc_id_i,
    input  logic [PORT_NUM-1:0][LA_W-1:0]            up_flit_la_i,
    output logic [PORT_NUM-1:0]                      dn_flit_v_o,
    output logic [PORT_NUM-1:0]                      dn_flit_pend_o,
    output logic [PORT_NUM-1:0][FLIT_W-1:0]          dn_flit_o,
    output logic [PORT_NUM-1:0][VC_ID_W-1:0]         dn_flit_vc_id_o,
    output logic [PORT_NUM-1:0][LA_W-1:0]            dn_flit_la_o,
    input  logic [PORT_NUM-1:0]                      dn_lcrd_v_i,
    input  logic [PORT_NUM-1:0][VC_ID_W-1:0]         dn_lcrd_id_i,
    output logic [PORT_NUM-1:0]                      up_lcrd_v_o,
    output logic [PORT_NUM-1:0][VC_ID_W-1:0]         up_lcrd_id_o,
    output logic [PORT_NUM-1:0][VC_NUM-1:0][CNT_W-1:0] crd_cnt_o,
    output logic [PORT_NUM-1:0]                      err_underflow_o,
    output logic [PORT_NUM-1:0]                      err_overflow_o,
    input  logic                                     err_clr_i
);

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port

        // ---------------- flit path ----------------
        if (FLIT_STAGES == 0) begin : g_flit_comb
            assign dn_flit_v_o[p]     = up_flit_v_i[p];
            assign dn_flit_pend_o[p]  = up_flit_pend_i[p];
            assign dn_flit_o[p]       = up_flit_i[p];
            assign dn_flit_vc_id_o[p] = up_flit_vc_id_i[p];
            assign dn_flit_la_o[p]    = up_flit_la_i[p];
        end else begin : g_flit_pipe
            logic               r_v    [FLIT_STAGES];
            logic               r_pend [FLIT_STAGES];
            logic [FLIT_W-1:0]  r_flit [FLIT_STAGES];
            logic [VC_ID_W-1:0] r_vc   [FLIT_STAGES];
            logic [LA_W-1:0]    r_la   [FLIT_STAGES];

            // Payload fields only move with a valid flit, which keeps the
            // wide registers quiet on idle cycles; pend is a hint that is
            // forwarded every cycle regardless of valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < FLIT_STAGES; s++) begin
                        r_v[s]    <= 1'b0;
                        r_pend[s] <= 1'b0;
                        r_flit[s] <= '0;
                        r_vc[s]   <= '0;
                        r_la[s]   <= '0;
                    end
                end else begin
                    r_v[0]    <= up_flit_v_i[p];
                    r_pend[0] <= up_flit_pend_i[p];
                    if (up_flit_v_i[p]) begin
                        r_flit[0] <= up_flit_i[p];
                        r_vc[0]   <= up_flit_vc_id_i[p];
                        r_la[0]   <= up_flit_la_i[p];
                    end
                    for (int s = 1; s < FLIT_STAGES; s++) begin
                        r_v[s]    <= r_v[s-1];
                        r_pend[s] <= r_pend[s-1];
                        if (r_v[s-1]) begin
                            r_flit[s] <= r_flit[s-1];
                            r_vc[s]   <= r_vc[s-1];
                            r_la[s]   <= r_la[s-1];
                        end
                    end
                end
            end

            assign dn_flit_v_o[p]     = r_v[FLIT_STAGES-1];
            assign dn_flit_pend_o[p]  = r_pend[FLIT_STAGES-1];
            assign dn_flit_o[p]       = r_flit[FLIT_STAGES-1];
            assign dn_flit_vc_id_o[p] = r_vc[FLIT_STAGES-1];
            assign dn_flit_la_o[p]    = r_la[FLIT_STAGES-1];
        end

        // ---------------- credit path ----------------
        if (CRD_STAGES == 0) begin : g_crd_comb
            assign up_lcrd_v_o[p]  = dn_lcrd_v_i[p];
            assign up_lcrd_id_o[p] = dn_lcrd_id_i[p];
        end else begin : g_crd_pipe
            logic               r_cv  [CRD_STAGES];
            logic [VC_ID_W-1:0] r_cid [CRD_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < CRD_STAGES; s++) begin
                        r_cv[s]  <= 1'b0;
                        r_cid[s] <= '0;
                    end
                end else begin
                    r_cv[0] <= dn_lcrd_v_i[p];
                    if (dn_lcrd_v_i[p]) begin
                        r_cid[0] <= dn_lcrd_id_i[p];
                    end
                    for (int s = 1; s < CRD_STAGES; s++) begin
                        r_cv[s] <= r_cv[s-1];
                        if (r_cv[s-1]) begin
                            r_cid[s] <= r_cid[s-1];
                        end
                    end
                end
            end

            assign up_lcrd_v_o[p]  = r_cv[CRD_STAGES-1];
            assign up_lcrd_id_o[p] = r_cid[CRD_STAGES-1];
        end

        // ---------------- credit shadow ----------------
`ifdef VNET_LINK_PIPE_CREDIT_CHECK_EN
        begin : g_shadow
            localparam logic [CNT_W-1:0] c_crd_init = CNT_W'(VC_DEPTH);

            logic [VC_NUM-1:0][CNT_W-1:0] r_cnt;
            logic                         r_err_uf;
            logic                         r_err_of;
            logic [VC_NUM-1:0]            w_dec;
            logic [VC_NUM-1:0]            w_inc;
            logic [VC_NUM-1:0]            w_uf;
            logic [VC_NUM-1:0]            w_of;
            logic                         w_bad_id;

            // Both events are observed at the upstream boundary: flits as
            // they leave the tx, credits as they reach it after retiming.
            always_comb begin
                w_dec = '0;
                w_inc = '0;
                w_uf  = '0;
                w_of  = '0;
                for (int v = 0; v < VC_NUM; v++) begin
                    w_dec[v] = up_flit_v_i[p] && (up_flit_vc_id_i[p] == VC_ID_W'(v));
                    w_inc[v] = up_lcrd_v_o[p] && (up_lcrd_id_o[p] == VC_ID_W'(v));
                    w_uf[v]  = w_dec[v] && !w_inc[v] && (r_cnt[v] == '0);
                    w_of[v]  = w_inc[v] && !w_dec[v] && (r_cnt[v] == c_crd_init);
                end
                w_bad_id = (up_flit_v_i[p] && (int'(up_flit_vc_id_i[p]) >= VC_NUM)) ||
                           (up_lcrd_v_o[p] && (int'(up_lcrd_id_o[p]) >= VC_NUM));
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int v = 0; v < VC_NUM; v++) begin
                        r_cnt[v] <= c_crd_init;
                    end
                    r_err_uf <= 1'b0;
                    r_err_of <= 1'b0;
                end else begin
                    for (int v = 0; v < VC_NUM; v++) begin
                        if (w_dec[v] && !w_inc[v] && (r_cnt[v] != '0)) begin
                            r_cnt[v] <= r_cnt[v] - 1'b1;
                        end else if (w_inc[v] && !w_dec[v] && (r_cnt[v] != c_crd_init)) begin
                            r_cnt[v] <= r_cnt[v] + 1'b1;
                        end
                    end
                    // A violation in the clear cycle re-sets the flag.
                    r_err_uf <= (r_err_uf && !err_clr_i) || (|w_uf);
                    r_err_of <= (r_err_of && !err_clr_i) || (|w_of) || w_bad_id;
                end
            end

            assign crd_cnt_o[p]       = r_cnt;
            assign err_underflow_o[p] = r_err_uf;
            assign err_overflow_o[p]  = r_err_of;
        end
`else
        begin : g_no_shadow
            assign crd_cnt_o[p]       = '0;
            assign err_underflow_o[p] = 1'b0;
            assign err_overflow_o[p]  = 1'b0;
        end
`endif
    end

`ifndef VNET_LINK_PIPE_CREDIT_CHECK_EN
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr_i;
`endif

endmodule
`default_nettype wire

// File: doc/vnet_link_pipe.md
Name: vnet_link_pipe

Overview:
- Parametrised multi-port inter-router link stage. Sits between a vnet_router's tx ports and the neighbour router's rx ports.
- Retimes the flit path and the credit-return path by independently configurable stage counts, so long mesh links close timing.
- Each link carries flit, pend, VC id and look-ahead route.
- Optionally keeps a per-VC credit shadow that flags protocol violations.

Parameters:
- PORT_NUM, 5, number of independent links.
- FLIT_W, 128, flit payload width.
- LA_W, 3, look-ahead routing field width (io_port_t width).
- VC_NUM, 6, VCs per link.
- VC_ID_W, $clog2(VC_NUM), VC id width.
- VC_DEPTH, 4, buffer depth per VC at the downstream rx; initial credit count.
- FLIT_STAGES, 1, register stages on the flit path (0..4); 0 = combinational pass-through.
- CRD_STAGES, 1, register stages on the credit path (0..4); 0 = combinational pass-through.
- CNT_W, $clog2(VC_DEPTH+1), credit counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- up_flit_v_i  in  [PORT_NUM]  flit valid from upstream tx.
- up_flit_pend_i  in  [PORT_NUM]  pend hint from upstream.
- up_flit_i  in  [PORT_NUM][FLIT_W]  flit payload.
- up_flit_vc_id_i  in  [PORT_NUM][VC_ID_W]  target VC.
- up_flit_la_i  in  [PORT_NUM][LA_W]  look-ahead route.
- dn_flit_v_o, dn_flit_pend_o, dn_flit_o, dn_flit_vc_id_o, dn_flit_la_o  out  same widths as inputs  delayed copy toward downstream rx.
- dn_lcrd_v_i  in  [PORT_NUM]  credit return valid from downstream.
- dn_lcrd_id_i  in  [PORT_NUM][VC_ID_W]  returned VC.
- up_lcrd_v_o, up_lcrd_id_o  out  same widths  delayed credit toward upstream tx.
- crd_cnt_o  out  [PORT_NUM][VC_NUM][CNT_W]  credit shadow per VC.
- err_underflow_o  out  [PORT_NUM]  sticky; flit sent with no credit.
- err_overflow_o  out  [PORT_NUM]  sticky; credit returned beyond VC_DEPTH.
- err_clr_i  in  1  clears both sticky error vectors.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - All stage registers, including payload, VC id, LA and pend, reset to 0.
  - dn_flit_v_o, dn_flit_pend_o and up_lcrd_v_o are 0 the cycle after rst is sampled high.
  - crd_cnt_o resets to VC_DEPTH for every VC.
  - err_* reset to 0.
  - With 0 stages, outputs follow inputs even during reset.
- Flit path:
  - Latency is exactly FLIT_STAGES cycles.
  - No backpressure: a shift pipeline that accepts every cycle.
  - v, pend, vc_id, la and payload move as one word.
  - Payload registers capture only when v=1. Pend captures every cycle.
- Credit path:
  - Latency is exactly CRD_STAGES cycles.
  - id captures only when v=1.
- Reset mid-operation: in-flight flits and credits are discarded. Counters return to VC_DEPTH.
- Credit shadow, per port and per VC, measured at the upstream boundary:
  - Decrement on up_flit_v_i with vc_id=v.
  - Increment on up_lcrd_v_o with id=v.
  - Same-cycle decrement and increment on the same VC: count unchanged, no error.
  - Decrement at 0 without a matching increment: count holds 0; err_underflow_o[p] sets.
  - Increment at VC_DEPTH without a matching decrement: count holds VC_DEPTH; err_overflow_o[p] sets.
  - VC id >= VC_NUM: ignored by the shadow and sets err_overflow_o[p].
- Error clear:
  - err_clr_i clears errors on the next edge.
  - A new violation in the same cycle as err_clr_i wins: the error bit stays 1.
- Independence: ports are fully independent. Only err_clr_i is shared.

Optional Feature:
- Macro: VNET_LINK_PIPE_CREDIT_CHECK_EN.
- Defined: the credit shadow and error logic are built as described above.
- Undefined:
  - No counters are synthesised.
  - crd_cnt_o is tied to 0.
  - err_underflow_o and err_overflow_o are tied to 0.
  - err_clr_i is ignored.
  - The flit and credit paths are unchanged.

Test Plan:
- Latency: FLIT_STAGES=2, CRD_STAGES=3; drive a flit on port 1, vc 2, payload 0xA5, at cycle 10 and a credit for vc 2 at cycle 10 -> dn flit at cycle 12 with vc 2 and payload 0xA5; up credit at cycle 13 with id 2.
- Streaming: FLIT_STAGES=0; 8 back-to-back flits on port 0 -> the same cycle on dn, in order, no bubbles; pend toggling is passed through every cycle.
- Underflow (CHECK_EN, VC_DEPTH=4): 5 flits on port 2, vc 0, no credits -> crd_cnt 4,3,2,1,0,0; err_underflow_o[2]=1 after the 5th flit; err_clr_i pulse -> 0 next cycle.
- Simultaneous events: vc 1 at count 0 sees a flit and a credit in the same cycle -> count stays 0, no error. Credit at count 4 with no flit -> err_overflow_o set, count stays 4.
- Reset mid-operation: flits in all 3 stages when rst is asserted for 1 cycle -> dn_flit_v_o=0 next cycle; no stale flit emerges afterwards; all counters read 4.
- Macro undefined: repeat the underflow test -> err_* and crd_cnt_o stay 0; flit and credit paths are unchanged.
